multi_timer: RTL and testbench

Parametrised successor to the single-compare SoC timer. It provides one shared 64-bit mtime counter with a programmable prescaler and NUM_TIMERS independent compare channels. Each channel runs one-shot or periodic (auto-reload), with sticky write-1-to-clear pending bits, per-channel enables and a combined interrupt. It sits behind the SoC's axi2mem-style register port next to the system controller.

---
 rtl/multi_timer_pkg.sv | 36 +++
 rtl/multi_timer_channel.sv | 90 +++++++++
 rtl/multi_timer.sv | 142 ++++++++++++++
 tb/tb_multi_timer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg
//   Shared definitions for the multi-channel timer: register offsets
//   (byte addresses of 64-bit words), CFG/CTRL field positions and a
//   byte-enable merge helper used by every writable register.
package multi_timer_pkg;

   localparam int unsigned ADDR_ID      = 'h00;
   localparam int unsigned ADDR_CTRL    = 'h08;
   localparam int unsigned ADDR_MTIME   = 'h10;
   localparam int unsigned ADDR_PENDING = 'h18;
   localparam int unsigned ADDR_IRQEN   = 'h20;
   localparam int unsigned CH_BASE      = 'h40;
   localparam int unsigned CH_STRIDE    = 'h10;
   localparam int unsigned CH_CFG_OFS   = 'h08;

   localparam int CFG_EN           = 0;
   localparam int CFG_PERIODIC     = 1;
   localparam int CFG_INTERVAL_LSB = 32;

   localparam int CTRL_RUN     = 0;
   localparam int CTRL_DIV_LSB = 16;

   localparam logic [7:0] ID_VERSION = 8'd1;

   // Written bytes take new_val, the rest keep old_val.
   function automatic logic [63:0] be_merge(input logic [63:0] old_val,
                                            input logic [63:0] new_val,
                                            input logic [7:0]  be);
      logic [63:0] res;
      for (int b = 0; b < 8; b++) begin
         res[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// multi_timer_channel
//   One compare channel: CMP and CFG registers, their write decode, the
//   hit compare against the shared mtime and the one-shot/periodic update.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     wr_en         register write strobe (already qualified by request)
//     addr          word-aligned byte address (low 3 bits zero)
//     be, wdata     byte enables and write data
//     mtime         registered shared counter
//     hit           combinational hit this cycle (sets pending in the top)
//     rdata         this channel's read data, zero when not addressed
module multi_timer_channel
   import multi_timer_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int IDX    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        be,
   input  logic [63:0]       wdata,
   input  logic [63:0]       mtime,
   output logic              hit,
   output logic [63:0]       rdata
);

   localparam logic [ADDR_W-1:0] CMP_ADDR = ADDR_W'(CH_BASE + CH_STRIDE * IDX);
   localparam logic [ADDR_W-1:0] CFG_ADDR = ADDR_W'(CH_BASE + CH_STRIDE * IDX + CH_CFG_OFS);

   logic [63:0] cmp_reg, cmp_next;
   logic        en_reg, en_next;
   logic        periodic_reg, periodic_next;
   logic [31:0] interval_reg, interval_next;
   logic [63:0] cfg_word;
   logic        wr_cmp, wr_cfg;

   assign cfg_word = {interval_reg, 30'd0, periodic_reg, en_reg};
   assign wr_cmp   = wr_en && (addr == CMP_ADDR);
   assign wr_cfg   = wr_en && (addr == CFG_ADDR);
   assign hit      = en_reg && (mtime >= cmp_reg);
   assign rdata    = (addr == CMP_ADDR) ? cmp_reg :
                     (addr == CFG_ADDR) ? cfg_word : 64'd0;

   // Hardware update first, then software bytes layered on top so a
   // same-cycle write wins only for the bytes it actually touches.
   always_comb begin
      cmp_next      = cmp_reg;
      en_next       = en_reg;
      periodic_next = periodic_reg;
      interval_next = interval_reg;
      if (hit) begin
         if (periodic_reg && (interval_reg != 32'd0)) begin
            cmp_next = cmp_reg + {32'd0, interval_reg};
         end else begin
            en_next = 1'b0;
         end
      end
      if (wr_cmp) begin
         cmp_next = be_merge(cmp_next, wdata, be);
      end
      if (wr_cfg) begin
         if (be[0]) begin
            en_next       = wdata[CFG_EN];
            periodic_next = wdata[CFG_PERIODIC];
         end
         for (int b = 4; b < 8; b++) begin
            if (be[b]) begin
               interval_next[(b-4)*8 +: 8] = wdata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_reg      <= '1;
         en_reg       <= 1'b0;
         periodic_reg <= 1'b0;
         interval_reg <= 32'd0;
      end else begin
         cmp_reg      <= cmp_next;
         en_reg       <= en_next;
         periodic_reg <= periodic_next;
         interval_reg <= interval_next;
      end
   end

endmodule

// File: rtl/multi_timer.sv
// multi_timer
//   Shared 64-bit mtime with prescaler plus NUM_TIMERS compare channels,
//   W1C pending bits, per-channel interrupt enables and a combined irq.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     i_req, i_we       access strobe, write(1)/read(0)
//     i_addr            byte address, bits [2:0] ignored
//     i_be, i_wdata     write byte enables and data
//     o_rdata           registered read data (1-cycle latency)
//     o_tick            prescaler tick, mtime increments at the next edge
//     o_irq_vec, o_irq  registered pending & irq_enable, and its OR
module multi_timer
   import multi_timer_pkg::*;
#(
   parameter int NUM_TIMERS = 4,
   parameter int PRESCALE_W = 16,
   parameter int ADDR_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic                  i_we,
   input  logic [ADDR_W-1:0]     i_addr,
   input  logic [7:0]            i_be,
   input  logic [63:0]           i_wdata,
   output logic [63:0]           o_rdata,
   output logic                  o_tick,
   output logic [NUM_TIMERS-1:0] o_irq_vec,
   output logic                  o_irq
);

   logic [ADDR_W-1:0]     addr_w;
   logic                  wr, rd;
   logic                  wr_ctrl, wr_mtime, wr_pend, wr_irqen;
   logic                  run_reg;
   logic [PRESCALE_W-1:0] div_reg, pre_cnt_reg;
   logic [63:0]           mtime_reg;
   logic [NUM_TIMERS-1:0] pending_reg, irqen_reg, hit_vec, w1c_mask;
   logic [63:0]           ctrl_word, ctrl_merged, id_word, rdata_mux;
   logic [63:0]           ch_rdata [NUM_TIMERS];
   logic                  tick;
   logic                  unused_bits;

   assign addr_w   = {i_addr[ADDR_W-1:3], 3'b000};
   assign wr       = i_req && i_we;
   assign rd       = i_req && !i_we;
   assign wr_ctrl  = wr && (addr_w == ADDR_W'(ADDR_CTRL));
   assign wr_mtime = wr && (addr_w == ADDR_W'(ADDR_MTIME));
   assign wr_pend  = wr && (addr_w == ADDR_W'(ADDR_PENDING));
   assign wr_irqen = wr && (addr_w == ADDR_W'(ADDR_IRQEN));

   assign tick     = run_reg && (pre_cnt_reg == div_reg);
   assign o_tick   = tick;
   assign id_word  = {48'd0, ID_VERSION, 4'd0, 4'(NUM_TIMERS)};
   assign w1c_mask = wr_pend ? (i_wdata[NUM_TIMERS-1:0] & {NUM_TIMERS{i_be[0]}}) : '0;

   always_comb begin
      ctrl_word = 64'd0;
      ctrl_word[CTRL_RUN] = run_reg;
      ctrl_word[CTRL_DIV_LSB +: PRESCALE_W] = div_reg;
   end
   assign ctrl_merged = be_merge(ctrl_word, i_wdata, i_be);
   // Reserved CTRL bits and the ignored address LSBs are intentionally dropped.
   assign unused_bits = ^{ctrl_merged, i_addr[2:0]};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TIMERS; gi++) begin : g_ch
         multi_timer_channel #(
            .ADDR_W (ADDR_W),
            .IDX    (gi)
         ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .wr_en (wr),
            .addr  (addr_w),
            .be    (i_be),
            .wdata (i_wdata),
            .mtime (mtime_reg),
            .hit   (hit_vec[gi]),
            .rdata (ch_rdata[gi])
         );
      end
   endgenerate

   // Channel read data is zero unless addressed, so an OR acts as the mux.
   always_comb begin
      rdata_mux = 64'd0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         rdata_mux = rdata_mux | ch_rdata[i];
      end
      if (addr_w == ADDR_W'(ADDR_ID))      rdata_mux = id_word;
      if (addr_w == ADDR_W'(ADDR_CTRL))    rdata_mux = ctrl_word;
      if (addr_w == ADDR_W'(ADDR_MTIME))   rdata_mux = mtime_reg;
      if (addr_w == ADDR_W'(ADDR_PENDING)) rdata_mux = 64'(pending_reg);
      if (addr_w == ADDR_W'(ADDR_IRQEN))   rdata_mux = 64'(irqen_reg);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_reg     <= 1'b0;
         div_reg     <= '0;
         pre_cnt_reg <= '0;
         mtime_reg   <= 64'd0;
         pending_reg <= '0;
         irqen_reg   <= '0;
         o_rdata     <= 64'd0;
         o_irq_vec   <= '0;
         o_irq       <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            run_reg     <= ctrl_merged[CTRL_RUN];
            div_reg     <= ctrl_merged[CTRL_DIV_LSB +: PRESCALE_W];
            pre_cnt_reg <= '0;
         end else if (run_reg) begin
            pre_cnt_reg <= tick ? '0 : pre_cnt_reg + 1'b1;
         end

         // A software write replaces the increment for that cycle.
         if (wr_mtime) begin
            mtime_reg <= be_merge(mtime_reg, i_wdata, i_be);
         end else if (tick) begin
            mtime_reg <= mtime_reg + 64'd1;
         end

         // Set has priority over a same-cycle clear.
         pending_reg <= (pending_reg & ~w1c_mask) | hit_vec;

         if (wr_irqen && i_be[0]) begin
            irqen_reg <= i_wdata[NUM_TIMERS-1:0];
         end

         o_irq_vec <= pending_reg & irqen_reg;
         o_irq     <= |(pending_reg & irqen_reg);

         if (rd) begin
            o_rdata <= rdata_mux;
         end
      end
   end

endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;

   localparam int NT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_req = 1'b0;
   logic          i_we = 1'b0;
   logic [7:0]    i_addr = 8'd0;
   logic [7:0]    i_be = 8'd0;
   logic [63:0]   i_wdata = 64'd0;
   logic [63:0]   o_rdata;
   logic          o_tick;
   logic [NT-1:0] o_irq_vec;
   logic          o_irq;

   int checks = 0;
   int errors = 0;
   int tick_cnt = 0;
   bit tick_win = 1'b0;
   int n;

   logic [63:0] exp_q[$];
   string       name_q[$];

   multi_timer #(.NUM_TIMERS(NT), .PRESCALE_W(16), .ADDR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_we      (i_we),
      .i_addr    (i_addr),
      .i_be      (i_be),
      .i_wdata   (i_wdata),
      .o_rdata   (o_rdata),
      .o_tick    (o_tick),
      .o_irq_vec (o_irq_vec),
      .o_irq     (o_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end else begin
         $display("ok   %s value=0x%0h", nm, act);
      end
   endtask

   // Scoreboard monitor: every read accepted at a clock edge is compared
   // against the oldest expected value right after that edge.
   always @(posedge clk) begin
      if (!rst && i_req && !i_we) begin
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read actual=0x%0h required=<none>", o_rdata);
         end else begin
            chk(name_q.pop_front(), o_rdata, exp_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (tick_win && o_tick) tick_cnt++;
   end

   // Tasks start just after a falling edge and return after the next one,
   // so each access occupies exactly one rising edge.
   task automatic wr(input logic [7:0] a, input logic [7:0] be, input logic [63:0] d);
      i_req = 1'b1; i_we = 1'b1; i_addr = a; i_be = be; i_wdata = d;
      @(negedge clk);
      i_req = 1'b0; i_we = 1'b0; i_be = 8'd0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [63:0] exp, input string nm);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      i_req = 1'b1; i_we = 1'b0; i_addr = a;
      @(negedge clk);
      i_req = 1'b0;
   endtask

   task automatic wait_vec(input int idx, input int max_cyc, output int cnt);
      cnt = 0;
      while (!o_irq_vec[idx] && cnt < max_cyc) begin
         @(negedge clk);
         cnt++;
      end
      if (!o_irq_vec[idx]) begin
         checks++;
         errors++;
         $display("FAIL wait_irq%0d timeout actual=0 required=1 after %0d cycles", idx, cnt);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset asserted with a CTRL write in flight: reset must win.
      repeat (2) @(negedge clk);
      i_req = 1'b1; i_we = 1'b1; i_addr = 8'h08; i_be = 8'hFF; i_wdata = 64'h1;
      @(negedge clk);
      rst = 1'b0; i_req = 1'b0; i_we = 1'b0; i_be = 8'd0;
      chk("rst_irq", 64'(o_irq), 64'd0);
      chk("rst_irq_vec", 64'(o_irq_vec), 64'd0);
      chk("rst_tick", 64'(o_tick), 64'd0);
      chk("rst_rdata", o_rdata, 64'd0);
      rd(8'h00, 64'h104, "id");
      rd(8'h03, 64'h104, "id_low_bits_ignored");
      rd(8'h10, 64'd0, "rst_mtime");
      rd(8'h08, 64'd0, "rst_ctrl");
      rd(8'h40, 64'hFFFF_FFFF_FFFF_FFFF, "rst_cmp0");
      rd(8'h48, 64'd0, "rst_cfg0");
      rd(8'h18, 64'd0, "rst_pending");

      // Prescaler: div=3 -> one tick every 4 cycles, 10 ticks in 41 cycles.
      tick_cnt = 0;
      tick_win = 1'b1;
      wr(8'h08, 8'hFF, 64'h3_0001);
      rd(8'h08, 64'h3_0001, "ctrl_readback");
      repeat (39) @(negedge clk);
      wr(8'h08, 8'hFF, 64'd0);
      tick_win = 1'b0;
      chk("tick_count", 64'(tick_cnt), 64'd10);
      rd(8'h10, 64'd10, "prescale_mtime");

      // One-shot on channel 0.
      wr(8'h10, 8'hFF, 64'd0);
      wr(8'h40, 8'hFF, 64'd20);
      wr(8'h48, 8'hFF, 64'd1);
      wr(8'h20, 8'hFF, 64'hF);
      wr(8'h08, 8'hFF, 64'h1);
      wait_vec(0, 100, n);
      chk("oneshot_latency", 64'(n), 64'd22);
      chk("oneshot_irq", 64'(o_irq), 64'd1);
      wr(8'h08, 8'hFF, 64'd0);
      rd(8'h18, 64'h1, "oneshot_pending");
      rd(8'h48, 64'd0, "oneshot_cfg0_cleared");
      rd(8'h40, 64'd20, "oneshot_cmp0");
      wr(8'h18, 8'h01, 64'h1);
      chk("w1c_irq_hold", 64'(o_irq), 64'd1);
      @(negedge clk);
      chk("w1c_irq_drop", 64'(o_irq), 64'd0);
      rd(8'h18, 64'd0, "w1c_pending");

      // Periodic on channel 1: hits at 10, 15, 20 with a slow tick.
      wr(8'h10, 8'hFF, 64'd0);
      wr(8'h50, 8'hFF, 64'd10);
      wr(8'h58, 8'hFF, 64'h0000_0005_0000_0003);
      wr(8'h08, 8'hFF, 64'h7_0001);
      for (int k = 0; k < 3; k++) begin
         wait_vec(1, 200, n);
         rd(8'h10, 64'(10 + 5 * k), $sformatf("periodic_hit%0d_mtime", k));
         wr(8'h18, 8'h01, 64'h2);
         @(negedge clk);
      end
      wr(8'h08, 8'hFF, 64'd0);
      rd(8'h50, 64'd25, "periodic_cmp1");
      rd(8'h58, 64'h0000_0005_0000_0003, "periodic_cfg1_en_kept");

      // W1C colliding with a hit on channel 2 (catch-up every cycle).
      wr(8'h58, 8'hFF, 64'd0);
      wr(8'h18, 8'hFF, 64'hF);
      wr(8'h10, 8'hFF, 64'd100);
      wr(8'h60, 8'hFF, 64'd0);
      wr(8'h68, 8'hFF, 64'h0000_0001_0000_0003);
      wr(8'h18, 8'h01, 64'h4);
      rd(8'h18, 64'h4, "w1c_vs_set");
      wr(8'h68, 8'hFF, 64'd0);
      rd(8'h60, 64'd3, "catchup_cmp2");
      rd(8'h18, 64'h4, "pending_kept_after_disable");
      wr(8'h18, 8'h01, 64'h4);
      rd(8'h18, 64'd0, "pending_cleared");

      // Byte write to MTIME while counting: no increment that cycle.
      wr(8'h08, 8'hFF, 64'h1);
      wr(8'h10, 8'hFF, 64'h1FE);
      wr(8'h10, 8'h01, 64'hAA);
      wr(8'h08, 8'hFF, 64'd0);
      rd(8'h10, 64'h1AB, "mtime_byte_write");

      // Wrap from all-ones.
      wr(8'h10, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      wr(8'h08, 8'hFF, 64'h1);
      wr(8'h08, 8'hFF, 64'd0);
      rd(8'h10, 64'd0, "mtime_wrap");

      // Unmapped addresses.
      rd(8'h80, 64'd0, "unmapped_0x80");
      rd(8'h28, 64'd0, "unmapped_0x28");
      wr(8'h80, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      wr(8'h88, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      rd(8'h40, 64'd20, "unmapped_wr_cmp0");
      rd(8'h20, 64'hF, "unmapped_wr_irqen");
      rd(8'h08, 64'd0, "unmapped_wr_ctrl");
      rd(8'h10, 64'd0, "unmapped_wr_mtime");
      rd(8'h80, 64'd0, "unmapped_0x80_again");

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
